// File: rtl/vreg_bank.sv
// Vector register bank: NUM_REGS x LANES x DATAWIDTH. It has two combinational read ports with write bypass and one masked/broadcast write port.
// Writes commit on the rising edge. A clear sweep takes NUM_REGS cycles, with ready low while it runs; writes are dropped and reads are zero during the sweep.
module vreg_bank #(
    parameter int NUM_REGS  = 16,
    parameter int LANES     = 16,
    parameter int DATAWIDTH = 8,
    parameter int ADDRW     = 5,
    parameter int ZERO_REG0 = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [ADDRW-1:0]           waddr,
    input  logic [LANES-1:0]           wmask,
    input  logic                       bcast,
    input  logic [LANES*DATAWIDTH-1:0] wd,
    input  logic [ADDRW-1:0]           ra1,
    input  logic [ADDRW-1:0]           ra2,
    output logic [LANES*DATAWIDTH-1:0] rd1,
    output logic [LANES*DATAWIDTH-1:0] rd2,
    input  logic                       clr_start,
    output logic                       ready
);

    localparam int               VW       = LANES * DATAWIDTH;
    localparam logic [ADDRW:0]   ADDR_LIM = (ADDRW + 1)'(NUM_REGS);
    localparam logic [ADDRW-1:0] LAST_REG = ADDRW'(NUM_REGS - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ADDRW-1:0] r_sweep_ptr;
    logic [ADDRW-1:0] w_sweep_ptr_nxt;
    logic             w_ready;
    logic             w_sweep_en;

    logic [VW-1:0]    r_mem [NUM_REGS];

    logic             w_wr_ok;
    logic [VW-1:0]    w_wr_old;
    logic [VW-1:0]    w_wr_new;

    // Addresses past the bank, and register 0 when hardwired, behave as "no register".
    function automatic logic addr_ok(input logic [ADDRW-1:0] a);
        return ({1'b0, a} < ADDR_LIM) && !((ZERO_REG0 != 0) && (a == '0));
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_CLEAR;
            r_sweep_ptr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sweep_ptr <= w_sweep_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sweep_ptr_nxt = r_sweep_ptr;
        case (r_state)
            ST_CLEAR: begin
                if (r_sweep_ptr == LAST_REG) begin
                    w_state_nxt     = ST_IDLE;
                    w_sweep_ptr_nxt = '0;
                end else begin
                    w_sweep_ptr_nxt = r_sweep_ptr + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clr_start) begin
                    w_state_nxt     = ST_CLEAR;
                    w_sweep_ptr_nxt = '0;
                end
            end
            default: begin
                w_state_nxt     = ST_CLEAR;
                w_sweep_ptr_nxt = '0;
            end
        endcase
    end

    always_comb begin
        w_ready    = (r_state == ST_IDLE);
        w_sweep_en = (r_state == ST_CLEAR);
    end

    assign ready   = w_ready;
    assign w_wr_ok = we && w_ready && addr_ok(waddr);

    always_comb begin
        w_wr_old = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (waddr == ADDRW'(i)) begin
                w_wr_old = r_mem[i];
            end
        end
    end

    // Post-write image of the target register; feeds both storage and the read bypass.
    always_comb begin
        w_wr_new = w_wr_old;
        for (int l = 0; l < LANES; l++) begin
            if (wmask[l]) begin
                w_wr_new[l*DATAWIDTH +: DATAWIDTH] = bcast ? wd[DATAWIDTH-1:0]
                                                           : wd[l*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_sweep_en && (r_sweep_ptr == ADDRW'(i))) begin
                    r_mem[i] <= '0;
                end else if (w_wr_ok && (waddr == ADDRW'(i))) begin
                    r_mem[i] <= w_wr_new;
                end
            end
        end
    end

    function automatic logic [VW-1:0] read_port(input logic [ADDRW-1:0] ra);
        logic [VW-1:0] v;
        v = '0;
        if (w_ready && addr_ok(ra)) begin
            if (w_wr_ok && (ra == waddr)) begin
                v = w_wr_new;
            end else begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (ra == ADDRW'(i)) begin
                        v = r_mem[i];
                    end
                end
            end
        end
        return v;
    endfunction

    always_comb begin
        rd1 = read_port(ra1);
        rd2 = read_port(ra2);
    end

endmodule

// File: doc/vreg_bank.md
VREG_BANK -- requirements
Module: vreg_bank

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of vector registers.
REQ-002 SHALL have parameter LANES, default 16, lanes per vector register.
REQ-003 SHALL have parameter DATAWIDTH, default 8, bits per lane.
REQ-004 SHALL have parameter ADDRW, default 5, register address width (2**ADDRW >= NUM_REGS).
REQ-005 SHALL have parameter ZERO_REG0, default 0; when 1, register 0 reads as zero and ignores writes.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port we  input  1  write enable.
REQ-009 SHALL have port waddr  input  ADDRW  write register address.
REQ-010 SHALL have port wmask  input  LANES  per-lane write enable.
REQ-011 SHALL have port bcast  input  1  broadcast mode: lane 0 of wd written to every masked lane.
REQ-012 SHALL have port wd  input  LANES*DATAWIDTH  write data, lane i at bits [i*DATAWIDTH +: DATAWIDTH].
REQ-013 SHALL have ports ra1, ra2  input  ADDRW each  read addresses.
REQ-014 SHALL have ports rd1, rd2  output  LANES*DATAWIDTH each  read data, combinational.
REQ-015 SHALL have port clr_start  input  1  request full-bank clear sweep.
REQ-016 SHALL have port ready  output  1  high when bank is in IDLE and accepts writes.

Function
REQ-017 SHALL implement FSM states CLEAR and IDLE.
REQ-018 CLEAR: SHALL zero register sweep_ptr each cycle, sweep_ptr counting 0..NUM_REGS-1, one register per cycle.
REQ-019 CLEAR -> IDLE SHALL occur on the cycle after register NUM_REGS-1 is cleared; full sweep takes exactly NUM_REGS cycles.
REQ-020 IDLE -> CLEAR SHALL occur on the rising edge where clr_start=1, sweep_ptr reset to 0.
REQ-021 clr_start during CLEAR SHALL be ignored (sweep not restarted).
REQ-022 ready SHALL equal 1 in IDLE, 0 in CLEAR.
REQ-023 Write commits at rising edge when we=1 and ready=1: for each lane i with wmask[i]=1, lane i <= (bcast ? wd lane 0 : wd lane i); lanes with wmask[i]=0 unchanged.
REQ-024 Writes with ready=0 SHALL be dropped without error.
REQ-025 Writes with waddr >= NUM_REGS, or waddr=0 when ZERO_REG0=1, SHALL be dropped.
REQ-026 Write in same cycle as clr_start=1 in IDLE SHALL commit; the sweep then starts next cycle and clears it.
REQ-027 Reads SHALL be combinational, zero added latency.
REQ-028 Read-during-write bypass: when we=1, ready=1, write valid per REQ-025 and ra==waddr, rdN SHALL present post-write value (masked/broadcast lanes from wd, others from storage) in same cycle.
REQ-029 rdN SHALL be all-zero when raN >= NUM_REGS, when raN=0 with ZERO_REG0=1, or while ready=0.
REQ-030 Both read ports SHALL be independent; ra1==ra2 returns identical data.

Reset
REQ-031 rst=1 at rising edge SHALL force state CLEAR, sweep_ptr=0, ready=0 from next cycle; storage contents undefined until swept.
REQ-032 rst asserted mid-sweep SHALL restart sweep at register 0.
REQ-033 rst SHALL take priority over we and clr_start.
REQ-034 After rst deasserts, ready SHALL rise exactly NUM_REGS cycles later; rd1/rd2 read zero throughout.

Verification
REQ-035 Reset, defaults: rst 1 cycle, release -> ready=0 for 16 cycles, then 1; rd1(ra1=3) = 0.
REQ-036 Masked write: we=1, waddr=2, wmask=0x0001, wd lane0=0xA5 -> next cycle rd1(ra1=2) lane0=0xA5, lanes1-15=0x00.
REQ-037 Broadcast: we=1, waddr=4, wmask=0xFFFF, bcast=1, wd lane0=0x3C, others 0x11 -> rd2(ra2=4) all lanes 0x3C.
REQ-038 Bypass: reg5 all 0x01; we=1, waddr=5, wmask=0x00F0, wd lanes=0x77, ra1=5 same cycle -> rd1 lanes4-7=0x77, others 0x01.
REQ-039 Clear/blocked write: clr_start=1 in IDLE, then we=1 waddr=1 wd=0xFF during sweep -> write dropped, ready rises 16 cycles later, reg1 reads 0.
REQ-040 Bounds: NUM_REGS=16, ADDRW=5, we=1 waddr=20 -> no register changes; ra1=20 -> rd1=0.
